// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_unit
//  Description : Multi-cycle RV64 control unit sequencing the single-word cpu
//                datapath for ld/lw, sd/sw, addi, add and sub.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int WORDSIZE = 64
) (
    input  logic                cu_clk,
    input  logic                cu_rst_n,
    input  logic [31:0]         cu_instr,
    input  logic                cu_instr_valid,
    output logic                cu_instr_ready,
    output logic [4:0]          cu_rf_addr_a,
    output logic [4:0]          cu_rf_addr_b,
    output logic [4:0]          cu_rf_write_addr,
    output logic                cu_rf_write_en,
    output logic [WORDSIZE-1:0] cu_immediate,
    output logic                cu_mux_0_sel,
    output logic                cu_mux_1_sel,
    output logic                cu_mux_2_sel,
    output logic [2:0]          cu_alu_operation,
    output logic                cu_dm_write_en,
    output logic                cu_illegal,
    output logic [31:0]         cu_retired
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;

    logic [2:0]          r_state;
    logic                r_live;
    logic                r_is_load;
    logic                r_is_store;
    logic                r_is_illegal;
    logic                r_rd_nz;
    logic [4:0]          r_addr_a;
    logic [4:0]          r_addr_b;
    logic [4:0]          r_write_addr;
    logic [WORDSIZE-1:0] r_imm;
    logic                r_mux0;
    logic                r_mux1;
    logic                r_mux2;
    logic [2:0]          r_alu_op;
    logic [31:0]         r_retired;

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_addi;
    logic                w_is_alu;
    logic                w_legal;
    logic                w_accept;
    logic [WORDSIZE-1:0] w_imm_i;
    logic [WORDSIZE-1:0] w_imm_s;
    logic [4:0]          w_addr_a;
    logic [4:0]          w_addr_b;
    logic [4:0]          w_write_addr;
    logic [WORDSIZE-1:0] w_imm;
    logic                w_mux0;
    logic                w_mux1;
    logic                w_mux2;
    logic [2:0]          w_alu_op;
    logic                w_rd_nz;

    assign w_opcode = cu_instr[6:0];
    assign w_rd     = cu_instr[11:7];
    assign w_funct3 = cu_instr[14:12];
    assign w_rs1    = cu_instr[19:15];
    assign w_rs2    = cu_instr[24:20];
    assign w_funct7 = cu_instr[31:25];

    // funct3 010/011 selects the word and doubleword access widths
    assign w_is_load  = (w_opcode == c_OP_LOAD)  && (w_funct3[2:1] == 2'b01);
    assign w_is_store = (w_opcode == c_OP_STORE) && (w_funct3[2:1] == 2'b01);
    assign w_is_addi  = (w_opcode == c_OP_IMM)   && (w_funct3 == 3'b000);
    assign w_is_alu   = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b000) &&
                        ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
    assign w_legal    = w_is_load || w_is_store || w_is_addi || w_is_alu;

    assign w_imm_i = {{(WORDSIZE-12){cu_instr[31]}}, cu_instr[31:20]};
    assign w_imm_s = {{(WORDSIZE-12){cu_instr[31]}}, cu_instr[31:25], cu_instr[11:7]};

    assign w_accept = cu_instr_ready && cu_instr_valid;

    always_comb begin
        w_addr_a     = 5'd0;
        w_addr_b     = 5'd0;
        w_write_addr = 5'd0;
        w_imm        = '0;
        w_mux0       = 1'b0;
        w_mux1       = 1'b0;
        w_mux2       = 1'b0;
        w_alu_op     = 3'b000;
        w_rd_nz      = 1'b0;
        if (w_is_load) begin
            w_addr_a     = w_rs1;
            w_write_addr = w_rd;
            w_imm        = w_imm_i;
            w_mux2       = 1'b1;
            w_rd_nz      = |w_rd;
        end else if (w_is_store) begin
            // store data travels on port A, the base address on port B
            w_addr_a = w_rs2;
            w_addr_b = w_rs1;
            w_imm    = w_imm_s;
            w_mux0   = 1'b1;
        end else if (w_is_addi) begin
            w_addr_a     = w_rs1;
            w_write_addr = w_rd;
            w_imm        = w_imm_i;
            w_rd_nz      = |w_rd;
        end else if (w_is_alu) begin
            w_addr_a     = w_rs1;
            w_addr_b     = w_rs2;
            w_write_addr = w_rd;
            w_mux1       = 1'b1;
            w_alu_op     = {2'b00, w_funct7[5]};
            w_rd_nz      = |w_rd;
        end
    end

    always_ff @(posedge cu_clk) begin
        if (!cu_rst_n) begin
            r_state      <= c_IDLE;
            r_live       <= 1'b0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_is_illegal <= 1'b0;
            r_rd_nz      <= 1'b0;
            r_addr_a     <= 5'd0;
            r_addr_b     <= 5'd0;
            r_write_addr <= 5'd0;
            r_imm        <= '0;
            r_mux0       <= 1'b0;
            r_mux1       <= 1'b0;
            r_mux2       <= 1'b0;
            r_alu_op     <= 3'b000;
            r_retired    <= 32'd0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state      <= c_DECODE;
                        r_is_load    <= w_is_load;
                        r_is_store   <= w_is_store;
                        r_is_illegal <= !w_legal;
                        r_rd_nz      <= w_rd_nz;
                        r_addr_a     <= w_addr_a;
                        r_addr_b     <= w_addr_b;
                        r_write_addr <= w_write_addr;
                        r_imm        <= w_imm;
                        r_mux0       <= w_mux0;
                        r_mux1       <= w_mux1;
                        r_mux2       <= w_mux2;
                        r_alu_op     <= w_alu_op;
                    end
                end
                c_DECODE: r_state <= r_is_illegal ? c_IDLE : c_EXEC;
                c_EXEC:   r_state <= (r_is_load || r_is_store) ? c_MEM : c_WB;
                c_MEM: begin
                    if (r_is_store) begin
                        r_state   <= c_IDLE;
                        r_retired <= r_retired + 32'd1;
                    end else begin
                        r_state <= c_WB;
                    end
                end
                c_WB: begin
                    r_state   <= c_IDLE;
                    r_retired <= r_retired + 32'd1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ready stays low for the first cycle after reset, hence the r_live gate
    assign cu_instr_ready   = r_live && (r_state == c_IDLE);
    assign cu_rf_addr_a     = r_addr_a;
    assign cu_rf_addr_b     = r_addr_b;
    assign cu_rf_write_addr = r_write_addr;
    assign cu_rf_write_en   = (r_state == c_WB) && r_rd_nz;
    assign cu_immediate     = r_imm;
    assign cu_mux_0_sel     = r_mux0;
    assign cu_mux_1_sel     = r_mux1;
    assign cu_mux_2_sel     = r_mux2;
    assign cu_alu_operation = r_alu_op;
    assign cu_dm_write_en   = (r_state == c_MEM) && r_is_store;
    assign cu_illegal       = (r_state == c_DECODE) && r_is_illegal;
    assign cu_retired       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_control_unit
//  Description : Self-checking bench for cpu_control_unit (vector table,
//                reset corner cases, randomized instructions vs. model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        chk_b;
        logic [4:0]  wa;
        logic        chk_wa;
        logic [63:0] imm;
        logic        m0;
        logic        m1;
        logic        m2;
        logic        chk_m2;
        logic [2:0]  op;
        int          lat;
        int          rf_cyc;
        int          dm_cyc;
    } exp_t;

    logic        cu_clk;
    logic        cu_rst_n;
    logic [31:0] cu_instr;
    logic        cu_instr_valid;
    logic        cu_instr_ready;
    logic [4:0]  cu_rf_addr_a;
    logic [4:0]  cu_rf_addr_b;
    logic [4:0]  cu_rf_write_addr;
    logic        cu_rf_write_en;
    logic [63:0] cu_immediate;
    logic        cu_mux_0_sel;
    logic        cu_mux_1_sel;
    logic        cu_mux_2_sel;
    logic [2:0]  cu_alu_operation;
    logic        cu_dm_write_en;
    logic        cu_illegal;
    logic [31:0] cu_retired;

    logic [84:0] ctl;
    logic [31:0] exp_retired;
    int          checks;
    int          failures;

    cpu_control_unit #(.WORDSIZE(64)) dut (
        .cu_clk           (cu_clk),
        .cu_rst_n         (cu_rst_n),
        .cu_instr         (cu_instr),
        .cu_instr_valid   (cu_instr_valid),
        .cu_instr_ready   (cu_instr_ready),
        .cu_rf_addr_a     (cu_rf_addr_a),
        .cu_rf_addr_b     (cu_rf_addr_b),
        .cu_rf_write_addr (cu_rf_write_addr),
        .cu_rf_write_en   (cu_rf_write_en),
        .cu_immediate     (cu_immediate),
        .cu_mux_0_sel     (cu_mux_0_sel),
        .cu_mux_1_sel     (cu_mux_1_sel),
        .cu_mux_2_sel     (cu_mux_2_sel),
        .cu_alu_operation (cu_alu_operation),
        .cu_dm_write_en   (cu_dm_write_en),
        .cu_illegal       (cu_illegal),
        .cu_retired       (cu_retired)
    );

    assign ctl = {cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr, cu_immediate,
                  cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation};

    initial cu_clk = 1'b0;
    always #5 cu_clk = ~cu_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cu_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // Reference decode: path length in states, immediate by plain arithmetic
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        int         s;
        int         n_states;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        e = '{default: 0};
        e.instr  = ins;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        s = 0;
        n_states = 0;
        case (opc)
            7'b0000011: if (f3 == 3'd2 || f3 == 3'd3) begin
                s = int'(ins[31:20]); n_states = 4;
                e.a = rs1; e.wa = rd; e.chk_wa = 1'b1; e.m2 = 1'b1; e.chk_m2 = 1'b1;
            end
            7'b0100011: if (f3 == 3'd2 || f3 == 3'd3) begin
                s = int'(f7) * 32 + int'(rd); n_states = 3;
                e.a = rs2; e.b = rs1; e.chk_b = 1'b1; e.m0 = 1'b1; e.dm_cyc = 3;
            end
            7'b0010011: if (f3 == 3'd0) begin
                s = int'(ins[31:20]); n_states = 3;
                e.a = rs1; e.wa = rd; e.chk_wa = 1'b1; e.chk_m2 = 1'b1;
            end
            7'b0110011: if (f3 == 3'd0 && (f7 == 7'd0 || f7 == 7'd32)) begin
                n_states = 3;
                e.a = rs1; e.b = rs2; e.chk_b = 1'b1; e.wa = rd; e.chk_wa = 1'b1;
                e.m1 = 1'b1; e.chk_m2 = 1'b1; e.op = (f7 == 7'd32) ? 3'd1 : 3'd0;
            end
            default: ;
        endcase
        if (s >= 2048) s -= 4096;
        e.imm    = 64'(longint'(s));
        e.legal  = (n_states != 0);
        e.lat    = e.legal ? n_states + 1 : 2;
        e.rf_cyc = (e.chk_wa && rd != 5'd0) ? n_states : 0;
        return e;
    endfunction

    task automatic run_one(input exp_t e);
        int          k, lat, w;
        int          rf_first, rf_cnt, dm_first, dm_cnt, ill_first, ill_cnt;
        logic [84:0] snap;
        logic        stable;
        string       t;
        t = $sformatf("%08h", e.instr);
        w = 0;
        while (!cu_instr_ready && w < 20) begin
            tick();
            w++;
        end
        chk({"ready_before_issue ", t}, 64'(cu_instr_ready), 64'd1);
        cu_instr = e.instr;
        cu_instr_valid = 1'b1;
        k = 0; lat = 0; stable = 1'b1; snap = '0;
        rf_first = 0; rf_cnt = 0; dm_first = 0; dm_cnt = 0; ill_first = 0; ill_cnt = 0;
        do begin
            tick();
            k++;
            if (k == 1) snap = ctl;
            else if (ctl !== snap) stable = 1'b0;
            if (cu_rf_write_en) begin rf_cnt++; if (rf_first == 0) rf_first = k; end
            if (cu_dm_write_en) begin dm_cnt++; if (dm_first == 0) dm_first = k; end
            if (cu_illegal)     begin ill_cnt++; if (ill_first == 0) ill_first = k; end
            if (cu_instr_ready) begin
                lat = k;
                cu_instr_valid = 1'b0;
            end else begin
                // valid must be ignored while busy
                cu_instr_valid = 1'($urandom);
                cu_instr = $urandom;
            end
        end while (lat == 0 && k < 12);
        if (e.legal) exp_retired = exp_retired + 32'd1;
        chk({"latency ", t}, 64'(lat), 64'(e.lat));
        chk({"rf_we_cycle ", t}, 64'(rf_first), 64'(e.rf_cyc));
        chk({"rf_we_count ", t}, 64'(rf_cnt), (e.rf_cyc != 0) ? 64'd1 : 64'd0);
        chk({"dm_we_cycle ", t}, 64'(dm_first), 64'(e.dm_cyc));
        chk({"dm_we_count ", t}, 64'(dm_cnt), (e.dm_cyc != 0) ? 64'd1 : 64'd0);
        chk({"illegal_count ", t}, 64'(ill_cnt), e.legal ? 64'd0 : 64'd1);
        chk({"illegal_cycle ", t}, 64'(ill_first), e.legal ? 64'd0 : 64'd1);
        chk({"ctl_stable ", t}, 64'(stable), 64'd1);
        chk({"retired ", t}, 64'(cu_retired), 64'(exp_retired));
        if (e.legal) begin
            chk({"addr_a ", t}, 64'(snap[84:80]), 64'(e.a));
            if (e.chk_b)  chk({"addr_b ", t}, 64'(snap[79:75]), 64'(e.b));
            if (e.chk_wa) chk({"write_addr ", t}, 64'(snap[74:70]), 64'(e.wa));
            chk({"immediate ", t}, snap[69:6], e.imm);
            chk({"mux0 ", t}, 64'(snap[5]), 64'(e.m0));
            chk({"mux1 ", t}, 64'(snap[4]), 64'(e.m1));
            if (e.chk_m2) chk({"mux2 ", t}, 64'(snap[3]), 64'(e.m2));
            chk({"alu_op ", t}, 64'(snap[2:0]), 64'(e.op));
        end
    endtask

    task automatic random_phase(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: begin r[6:0] = 7'b0000011; r[14:13] = 2'b01; end
                1: begin r[6:0] = 7'b0100011; r[14:13] = 2'b01; end
                2: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
                3: begin
                    r[6:0] = 7'b0110011; r[14:12] = 3'b000;
                    r[31:25] = r[25] ? 7'b0100000 : 7'b0000000;
                end
                4: r[6:0] = r[0] ? 7'b0000011 : 7'b0110011;
                default: ;
            endcase
            run_one(model(r));
        end
    endtask

    exp_t tbl [11];

    initial begin
        checks = 0;
        failures = 0;
        exp_retired = 32'd0;
        //           instr        lg a  b  cb wa cw imm                     m0 m1 m2 c2 op lat rf dm
        tbl[0]  = '{32'h000100B3, 1, 2, 0, 1, 1, 1, 64'd0,                  0, 1, 0, 1, 0, 4, 3, 0};
        tbl[1]  = '{32'h402000B3, 1, 0, 2, 1, 1, 1, 64'd0,                  0, 1, 0, 1, 1, 4, 3, 0};
        tbl[2]  = '{32'h0053B103, 1, 7, 0, 0, 2, 1, 64'd5,                  0, 0, 1, 1, 0, 5, 4, 0};
        tbl[3]  = '{32'h00413BA3, 1, 4, 2, 1, 0, 0, 64'h17,                 1, 0, 0, 0, 0, 4, 0, 3};
        tbl[4]  = '{32'hFFF00193, 1, 0, 0, 0, 3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, 4, 3, 0};
        tbl[5]  = '{32'h00100013, 1, 0, 0, 0, 0, 1, 64'd1,                  0, 0, 0, 1, 0, 4, 0, 0};
        tbl[6]  = '{32'h00000000, 0, 0, 0, 0, 0, 0, 64'd0,                  0, 0, 0, 0, 0, 2, 0, 0};
        tbl[7]  = '{32'h02000033, 0, 0, 0, 0, 0, 0, 64'd0,                  0, 0, 0, 0, 0, 2, 0, 0};
        tbl[8]  = '{32'h00000003, 0, 0, 0, 0, 0, 0, 64'd0,                  0, 0, 0, 0, 0, 2, 0, 0};
        tbl[9]  = '{32'hFFC0A283, 1, 1, 0, 0, 5, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 1, 0, 5, 4, 0};
        tbl[10] = '{32'hFE322C23, 1, 3, 4, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0, 0, 4, 0, 3};

        cu_rst_n = 1'b0;
        cu_instr = 32'd0;
        cu_instr_valid = 1'b0;
        tick();
        tick();
        chk("reset_ready", 64'(cu_instr_ready), 64'd0);
        chk("reset_retired", 64'(cu_retired), 64'd0);
        chk("reset_outputs_zero", 64'(|{ctl, cu_rf_write_en, cu_dm_write_en, cu_illegal}), 64'd0);
        cu_rst_n = 1'b1;
        tick();
        chk("ready_after_release", 64'(cu_instr_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            run_one(tbl[i]);
            if (i == 1) chk("retired_after_add_sub", 64'(cu_retired), 64'd2);
        end

        // reset while a store sits in MEM
        while (!cu_instr_ready) tick();
        cu_instr = 32'h00413BA3;
        cu_instr_valid = 1'b1;
        tick();
        cu_instr_valid = 1'b0;
        tick();
        tick();
        chk("store_mem_dm_we", 64'(cu_dm_write_en), 64'd1);
        cu_rst_n = 1'b0;
        tick();
        chk("midrst_dm_we", 64'(cu_dm_write_en), 64'd0);
        chk("midrst_ready", 64'(cu_instr_ready), 64'd0);
        chk("midrst_retired", 64'(cu_retired), 64'd0);
        chk("midrst_outputs_zero", 64'(|{ctl, cu_rf_write_en, cu_illegal}), 64'd0);
        tick();
        chk("midrst_hold_dm_we", 64'(cu_dm_write_en), 64'd0);
        cu_rst_n = 1'b1;
        exp_retired = 32'd0;
        tick();
        chk("midrst_release_ready", 64'(cu_instr_ready), 64'd1);
        run_one(model(32'h000100B3));
        run_one(model(32'h00413BA3));

        random_phase(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
